// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports, one write port; self-clears after reset.
// Zero read latency; writes are dropped (and DropW set) until clear ends; REGFILE_BYPASS_EN adds write-to-read forwarding.
module reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WE3,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic [31:0] WD3,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        Ready,
  output logic        DropW
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx, idx_nxt;
  logic        clr_en;
  logic        wr_en;
  logic        read_ok;
  logic [31:0] rd1_arr, rd2_arr;
  logic [31:0] mem [0:31];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx   <= 5'd1;
      DropW <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == CLEAR && WE3) begin
        DropW <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_en    = 1'b0;
    wr_en     = 1'b0;
    case (state)
      CLEAR: begin
        clr_en = 1'b1;
        // Index saturates at 31; the final clear hands over to RUN.
        if (idx == 5'd31) begin
          state_nxt = RUN;
        end else begin
          idx_nxt = idx + 5'd1;
        end
      end
      RUN: begin
        wr_en = WE3 && (A3 != 5'd0);
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Entry 0 is never written; reads of address 0 are forced to zero below.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_en) begin
        mem[idx] <= 32'd0;
      end else if (wr_en) begin
        mem[A3] <= WD3;
      end
    end
  end

  assign Ready   = (state == RUN);
  assign read_ok = rst_n && (state == RUN);

  always_comb begin
    rd1_arr = (A1 == 5'd0) ? 32'd0 : mem[A1];
    rd2_arr = (A2 == 5'd0) ? 32'd0 : mem[A2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (A3 == A1)) begin
      rd1_arr = WD3;
    end
    if (wr_en && (A3 == A2)) begin
      rd2_arr = WD3;
    end
`endif
    RD1 = read_ok ? rd1_arr : 32'd0;
    RD2 = read_ok ? rd2_arr : 32'd0;
  end

endmodule
